// File: rtl/vga_grid_capture.sv
// vga_grid_capture: rebuilds the Game-of-Life cell grid from a VGA stream.
// Samples each cell centre on the active raster and commits once per frame.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   hsync_in     horizontal sync, active-low
//   vsync_in     vertical sync, active-low
//   red          pixel red (used only with GRID_CAPTURE_POPCOUNT_EN)
//   green        pixel green, alive decision
//   blue         pixel blue (ignored)
//   grid_out     last committed grid, bit r*GRID_N+c = cell (r,c)
//   frame_valid  one-cycle pulse when grid_out updates
//   frame_cnt    committed frames, wrapping
//   sync_err     sticky, a frame ended with a wrong sample count
//   live_cnt     set bits in grid_out (GRID_CAPTURE_POPCOUNT_EN only)
//
// Option macro GRID_CAPTURE_POPCOUNT_EN: adds live_cnt and requires
// red < ALIVE_THR for a live cell, rejecting white/red overlays.

module vga_grid_capture #(
    parameter int GRID_N    = 20,
    parameter int CELL_PX   = 16,
    parameter int GRID_X0   = 160,
    parameter int GRID_Y0   = 80,
    parameter int H_BP      = 48,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int ALIVE_THR = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic [3:0]                 red,
    input  logic [3:0]                 green,
    input  logic [3:0]                 blue,
    output logic [GRID_N*GRID_N-1:0]   grid_out,
    output logic                       frame_valid,
    output logic [15:0]                frame_cnt,
`ifdef GRID_CAPTURE_POPCOUNT_EN
    output logic [8:0]                 live_cnt,
`endif
    output logic                       sync_err
);

    localparam int NN = GRID_N * GRID_N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // px/ln counter values at the first sample point of the grid
    localparam int XS = H_BP + GRID_X0 + CELL_PX / 2;
    localparam int YS = V_BP + GRID_Y0 + CELL_PX / 2;

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        ACTIVE,
        COMMIT
    } state_t;

    state_t state, state_n;

    logic hs_q, hs_qq, vs_q, vs_qq;
    logic [3:0] g_q, r_q;
    logic hs_rise, hs_fall, vs_rise, vs_fall;

    logic [DW-1:0] div_cnt;
    logic tick;
    logic [10:0] px_cnt;
    logic [9:0] ln_cnt;

    logic [NN-1:0] shadow;
    logic [15:0] samp_cnt;

    logic col_hit, row_hit;
    logic [IW-1:0] cell_idx;
    logic alive;

    logic clr_samp, do_samp, do_commit;
    logic [8:0] pop;

    logic unused_inputs;
    assign unused_inputs = ^{blue, red};

    // Input register plus one delayed copy for edge detection. Syncs reset
    // to their idle (deasserted) level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            g_q   <= '0;
            r_q   <= '0;
        end else begin
            hs_q  <= hsync_in;
            hs_qq <= hs_q;
            vs_q  <= vsync_in;
            vs_qq <= vs_q;
            g_q   <= green;
            r_q   <= red;
        end
    end

    assign hs_rise = hs_q & ~hs_qq;
    assign hs_fall = ~hs_q & hs_qq;
    assign vs_rise = vs_q & ~vs_qq;
    assign vs_fall = ~vs_q & vs_qq;

    assign tick = (div_cnt == '0);

    // Pixel phase realigns to every line on hsync deassertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (hs_rise) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_cnt <= '0;
        end else if (hs_rise) begin
            px_cnt <= '0;
        end else if (tick && px_cnt != 11'h7FF) begin
            px_cnt <= px_cnt + 1'b1;
        end
    end

    // vsync clear wins over a coincident hsync edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ln_cnt <= '0;
        end else if (vs_rise) begin
            ln_cnt <= '0;
        end else if (hs_fall && ln_cnt != 10'h3FF) begin
            ln_cnt <= ln_cnt + 1'b1;
        end
    end

    // Cell-centre match: one comparator per column and per row.
    always_comb begin
        int col_i;
        int row_i;
        col_hit  = 1'b0;
        row_hit  = 1'b0;
        col_i    = 0;
        row_i    = 0;
        for (int c = 0; c < GRID_N; c++) begin
            if (int'(px_cnt) == XS + c * CELL_PX) begin
                col_hit = 1'b1;
                col_i   = c;
            end
        end
        for (int r = 0; r < GRID_N; r++) begin
            if (int'(ln_cnt) == YS + r * CELL_PX) begin
                row_hit = 1'b1;
                row_i   = r;
            end
        end
        cell_idx = IW'(row_i * GRID_N + col_i);
    end

`ifdef GRID_CAPTURE_POPCOUNT_EN
    assign alive = (int'(g_q) >= ALIVE_THR) && (int'(r_q) < ALIVE_THR);
`else
    assign alive = (int'(g_q) >= ALIVE_THR);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_VSYNC;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_samp  = 1'b0;
        do_samp   = 1'b0;
        do_commit = 1'b0;
        unique case (state)
            WAIT_VSYNC: begin
                if (vs_rise) begin
                    state_n  = ACTIVE;
                    clr_samp = 1'b1;
                end
            end
            ACTIVE: begin
                if (tick && col_hit && row_hit) begin
                    do_samp = 1'b1;
                end
                if (vs_fall) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_n   = WAIT_VSYNC;
            end
            default: begin
                state_n = WAIT_VSYNC;
            end
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NN; i++) begin
            pop = pop + 9'(shadow[i]);
        end
    end

    // samp_cnt saturates so a runaway frame can never wrap back to NN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow   <= '0;
            samp_cnt <= '0;
        end else begin
            if (clr_samp) begin
                samp_cnt <= '0;
            end
            if (do_samp) begin
                shadow[cell_idx] <= alive;
                if (samp_cnt != 16'hFFFF) begin
                    samp_cnt <= samp_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_out    <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            sync_err    <= 1'b0;
`ifdef GRID_CAPTURE_POPCOUNT_EN
            live_cnt    <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            if (do_commit) begin
                if (samp_cnt == 16'(NN)) begin
                    grid_out    <= shadow;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 1'b1;
`ifdef GRID_CAPTURE_POPCOUNT_EN
                    live_cnt    <= pop;
`endif
                end else begin
                    sync_err <= 1'b1;
                end
            end
        end
    end

`ifndef GRID_CAPTURE_POPCOUNT_EN
    logic unused_pop;
    assign unused_pop = ^pop;
`endif

endmodule
